// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory handshakes around mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory.
// Data wins contention unless the fetch has been starved for STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.i_req) begin
          starve_d = '0;
        end
        // While a valid pulse is out its requester still shows the old req: grant nothing.
        if (!i_valid_q && !d_valid_q) begin
          if (bus.d_req && (!bus.i_req || (starve_q < StarveMax))) begin
            state_d = StServeD;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
            if (bus.i_req) begin
              starve_d = starve_q + CntW'(1);
            end
          end else if (bus.i_req) begin
            state_d  = StServeI;
            addr_d   = bus.i_addr;
            we_d     = 1'b0;
            starve_d = '0;
          end
        end
      end
      StServeI: begin
        if (bus.mem_ack) begin
          state_d   = StIdle;
          i_rdata_d = bus.mem_rdata;
          i_valid_d = 1'b1;
        end
      end
      StServeD: begin
        if (bus.mem_ack) begin
          state_d   = StIdle;
          d_valid_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_req   = (state_q != StIdle);
  assign bus.mem_we    = (state_q == StServeD) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_if  = bus.i_req & ~i_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Stimulus knobs
  bit          i_go, d_go, rand_mode, spur, hold_rst;
  logic [31:0] i_addr_nxt, d_addr_nxt, d_wdata_nxt;
  bit          d_we_nxt;
  int          ack_delay, srv_cnt;
  bit          i_pend, d_pend;
  logic [31:0] mem [256];

  // Reference model: one outstanding access, who owns it, and the run of data grants
  // that have overtaken a waiting fetch.
  bit          m_busy, m_own_d, m_we, m_vi, m_vd;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int unsigned m_run;

  int          rc;
  logic        mreq_log [64];
  logic        ivalid_log [64];
  logic        dvalid_log [64];
  logic        stall_if_log [64];
  logic        mwe_log [64];
  logic [31:0] maddr_log [64];
  logic [31:0] mwdata_log [64];
  logic [31:0] grants [$];
  logic        prev_mreq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_own_d  = 1'b0;
    m_we     = 1'b0;
    m_vi     = 1'b0;
    m_vd     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_irdata = '0;
    m_drdata = '0;
    m_run    = 0;
  endtask

  // Predicts the next cycle from the inputs presented in this one.
  task automatic model_step();
    bit was_v;
    was_v = m_vi | m_vd;
    m_vi  = 1'b0;
    m_vd  = 1'b0;
    if (m_busy) begin
      if (bus.mem_ack) begin
        m_busy = 1'b0;
        if (m_own_d) begin
          m_vd = 1'b1;
          if (!m_we) m_drdata = bus.mem_rdata;
        end else begin
          m_vi     = 1'b1;
          m_irdata = bus.mem_rdata;
        end
      end
    end else begin
      if (!bus.i_req) m_run = 0;
      if (!was_v) begin
        if (bus.d_req && (!bus.i_req || m_run < SMAX)) begin
          m_busy  = 1'b1;
          m_own_d = 1'b1;
          m_addr  = bus.d_addr;
          m_we    = bus.d_we;
          m_wdata = bus.d_wdata;
          if (bus.i_req) m_run++;
        end else if (bus.i_req) begin
          m_busy  = 1'b1;
          m_own_d = 1'b0;
          m_addr  = bus.i_addr;
          m_we    = 1'b0;
          m_run   = 0;
        end
      end
    end
  endtask

  task automatic step();
    logic [7:0] idx;
    @(negedge clk);
    rc++;
    chk("i_valid", bus.i_valid, m_vi);
    chk("d_valid", bus.d_valid, m_vd);
    chk("i_rdata", bus.i_rdata, m_irdata);
    chk("d_rdata", bus.d_rdata, m_drdata);
    chk("mem_req", bus.mem_req, m_busy);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_we", bus.mem_we, m_busy && m_own_d && m_we);
    if (m_busy && m_own_d && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    if (rc >= 0 && rc < 64) begin
      mreq_log[rc]   = bus.mem_req;
      ivalid_log[rc] = bus.i_valid;
      dvalid_log[rc] = bus.d_valid;
      mwe_log[rc]    = bus.mem_we;
      maddr_log[rc]  = bus.mem_addr;
      mwdata_log[rc] = bus.mem_wdata;
    end
    if (bus.mem_req && !prev_mreq) grants.push_back(bus.mem_addr);
    prev_mreq = bus.mem_req;

    // Requesters hold until their valid pulse, then may issue again at once.
    if (bus.i_valid) i_pend = 1'b0;
    if (bus.d_valid) d_pend = 1'b0;
    if (rand_mode) begin
      i_go = ($urandom_range(0, 2) == 0);
      d_go = ($urandom_range(0, 2) == 0);
    end
    if (!i_pend && i_go) begin
      i_pend     = 1'b1;
      bus.i_addr = rand_mode ? (32'($urandom_range(0, 255)) << 2) : i_addr_nxt;
    end
    if (!d_pend && d_go) begin
      d_pend = 1'b1;
      if (rand_mode) begin
        bus.d_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.d_we    = ($urandom_range(0, 1) == 1);
        bus.d_wdata = $urandom;
      end else begin
        bus.d_addr  = d_addr_nxt;
        bus.d_we    = d_we_nxt;
        bus.d_wdata = d_wdata_nxt;
      end
    end
    bus.i_req = i_pend;
    bus.d_req = d_pend;

    // Memory: acks after ack_delay extra cycles of mem_req.
    if (bus.mem_req) begin
      if (srv_cnt >= ack_delay) begin
        idx         = bus.mem_addr[9:2];
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem[idx]      = bus.mem_wdata;
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_rdata = mem[idx];
        end
        srv_cnt = 0;
        if (rand_mode) ack_delay = $urandom_range(0, 3);
      end else begin
        bus.mem_ack = 1'b0;
        srv_cnt++;
      end
    end else begin
      bus.mem_ack   = spur || (rand_mode && $urandom_range(0, 7) == 0);
      bus.mem_rdata = $urandom;
      srv_cnt       = 0;
    end
    rst = !hold_rst;
    #1;
    chk("stall_if", bus.stall_if, bus.i_req & ~m_vi);
    chk("stall_mem", bus.stall_mem, bus.d_req & ~m_vd);
    if (rc >= 0 && rc < 64) stall_if_log[rc] = bus.stall_if;
    if (!rst) begin
      model_reset();
      srv_cnt = 0;
    end else begin
      model_step();
    end
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rand_mode = 1'b0;
    i_go      = 1'b0;
    d_go      = 1'b0;
    spur      = 1'b0;
    while ((i_pend || d_pend || bus.mem_req) && n < 200) begin
      step();
      n++;
    end
    chk("drain_bound", n < 200, 1'b1);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h04] = 32'h0050_0093;
    mem[8'h11] = 32'h1234_5678;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    model_reset();
    hold_rst = 1'b1;
    ack_delay = 0; srv_cnt = 0; rc = -100; prev_mreq = 1'b0;
    step();
    step();
    hold_rst = 1'b0;
    step();

    // Fetch with ack on the third serve cycle
    ack_delay = 2; i_addr_nxt = 32'h10;
    rc = -1; i_go = 1'b1; step(); i_go = 1'b0;
    repeat (7) step();
    chk("fetch_mreq_c0", mreq_log[0], 1'b0);
    for (int k = 1; k <= 3; k++) chk("fetch_mreq_serve", mreq_log[k], 1'b1);
    chk("fetch_mreq_c4", mreq_log[4], 1'b0);
    chk("fetch_addr", maddr_log[1], 32'h10);
    chk("fetch_ivalid_c3", ivalid_log[3], 1'b0);
    chk("fetch_ivalid_c4", ivalid_log[4], 1'b1);
    chk("fetch_ivalid_c5", ivalid_log[5], 1'b0);
    for (int k = 0; k <= 3; k++) chk("fetch_stall_if", stall_if_log[k], 1'b1);
    chk("fetch_stall_if_c4", stall_if_log[4], 1'b0);
    chk("fetch_rdata", bus.i_rdata, 32'h0050_0093);

    // Contention: data first, fetch after
    ack_delay = 0; i_addr_nxt = 32'h20; d_addr_nxt = 32'h44; d_we_nxt = 1'b0;
    rc = -1; i_go = 1'b1; d_go = 1'b1; step(); i_go = 1'b0; d_go = 1'b0;
    repeat (7) step();
    chk("cont_data_addr", maddr_log[1], 32'h44);
    chk("cont_dvalid_c2", dvalid_log[2], 1'b1);
    chk("cont_ivalid_c2", ivalid_log[2], 1'b0);
    chk("cont_instr_addr", maddr_log[4], 32'h20);
    chk("cont_ivalid_c5", ivalid_log[5], 1'b1);
    chk("cont_d_rdata", bus.d_rdata, 32'h1234_5678);

    // Store leaves d_rdata alone
    d_addr_nxt = 32'h40; d_we_nxt = 1'b1; d_wdata_nxt = 32'hDEAD_BEEF;
    rc = -1; d_go = 1'b1; step(); d_go = 1'b0;
    repeat (4) step();
    chk("store_mem_we", mwe_log[1], 1'b1);
    chk("store_wdata", mwdata_log[1], 32'hDEAD_BEEF);
    chk("store_dvalid", dvalid_log[2], 1'b1);
    chk("store_d_rdata", bus.d_rdata, 32'h1234_5678);
    d_we_nxt = 1'b0;
    rc = -1; d_go = 1'b1; step(); d_go = 1'b0;
    repeat (4) step();
    chk("store_readback", bus.d_rdata, 32'hDEAD_BEEF);

    // Starvation: fetch gets every fifth grant
    ack_delay = 0; i_addr_nxt = 32'h100; d_addr_nxt = 32'h200;
    grants.delete();
    i_go = 1'b1; d_go = 1'b1;
    repeat (32) step();
    drain();
    chk("starve_grant_cnt", grants.size() >= 10, 1'b1);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      chk("starve_order", grants[k], (k % 5 == 4) ? 32'h100 : 32'h200);

    // Spurious ack while idle
    spur = 1'b1;
    rc = -1;
    repeat (4) step();
    spur = 1'b0;
    step();
    for (int k = 0; k <= 4; k++) begin
      chk("spur_mreq", mreq_log[k], 1'b0);
      chk("spur_ivalid", ivalid_log[k], 1'b0);
      chk("spur_dvalid", dvalid_log[k], 1'b0);
    end
    chk("spur_d_rdata", bus.d_rdata, m_drdata);

    // Reset in the middle of a data access
    ack_delay = 1000; d_addr_nxt = 32'h80; d_we_nxt = 1'b0;
    d_go = 1'b1; step(); d_go = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_d_valid", bus.d_valid, 1'b0);
    chk("rst_i_valid", bus.i_valid, 1'b0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    model_reset();
    srv_cnt = 0;
    hold_rst = 1'b1;
    step();
    step();
    ack_delay = 0;
    hold_rst  = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      step();
      if (bus.d_valid) got = 1;
    end
    chk("rst_regrant", got, 1);
    step();

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_req, input, 1 bit: instruction-fetch request.
REQ-007 The block SHALL have port i_addr, input, ADDR_W bits: fetch address.
REQ-008 The block SHALL have port i_rdata, output, DATA_W bits: fetched instruction.
REQ-009 The block SHALL have port i_valid, output, 1 bit: fetch-complete pulse.
REQ-010 The block SHALL have port d_req, input, 1 bit: data-access request.
REQ-011 The block SHALL have port d_we, input, 1 bit: 1 = store, 0 = load.
REQ-012 The block SHALL have port d_addr, input, ADDR_W bits: data address.
REQ-013 The block SHALL have port d_wdata, input, DATA_W bits: store data.
REQ-014 The block SHALL have port d_rdata, output, DATA_W bits: load data.
REQ-015 The block SHALL have port d_valid, output, 1 bit: data-complete pulse.
REQ-016 The block SHALL have port mem_req, output, 1 bit: request to the shared single-port memory.
REQ-017 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-018 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-019 The block SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-020 The block SHALL have port mem_ack, input, 1 bit: memory completion, variable latency.
REQ-021 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid with mem_ack.
REQ-022 The block SHALL have port stall_if, output, 1 bit: freezes PC and IF/ID.
REQ-023 The block SHALL have port stall_mem, output, 1 bit: freezes the pipeline at the MEM stage.

Function
REQ-024 The FSM SHALL have states IDLE, SERVE_I and SERVE_D.
REQ-025 A requester SHALL hold req, addr, we and wdata stable until it receives its valid pulse.
REQ-026 IDLE transitions SHALL be: if d_req and (!i_req or starve_cnt < STARVE_MAX), go to SERVE_D; else if i_req, go to SERVE_I; else stay in IDLE.
REQ-027 On a grant, the block SHALL latch the granted address, we and wdata into internal registers.
REQ-028 mem_addr, mem_we and mem_wdata SHALL be driven from the latched registers, not from the inputs.
REQ-029 mem_req SHALL be 1 in SERVE_I and SERVE_D and 0 in IDLE.
REQ-030 mem_we SHALL be 0 in SERVE_I, equal latched d_we in SERVE_D, and 0 in IDLE.
REQ-031 In a SERVE state with mem_ack=1, the next state SHALL be IDLE.
REQ-032 In that case x_rdata SHALL capture mem_rdata on loads or fetches, and x_valid SHALL be 1 for exactly one cycle.
REQ-033 Minimum latency, with mem_ack in the first SERVE cycle, SHALL be 2 cycles from the IDLE grant cycle to x_valid.
REQ-034 On stores, d_rdata SHALL hold its previous value and d_valid SHALL still pulse.
REQ-035 In the cycle x_valid=1, the arbiter SHALL ignore x_req so a request is never double-served.
REQ-036 mem_ack SHALL be ignored in IDLE, with no state or output change.
REQ-037 stall_if SHALL be combinational: i_req & ~i_valid.
REQ-038 stall_mem SHALL be combinational: d_req & ~d_valid.
REQ-039 starve_cnt SHALL be a saturating counter of width clog2(STARVE_MAX+1).
REQ-040 starve_cnt SHALL increment on each SERVE_D grant made while i_req=1.
REQ-041 starve_cnt SHALL clear on a SERVE_I grant, or in IDLE when i_req=0.
REQ-042 Reaching starve_cnt = STARVE_MAX with i_req=1 SHALL force the next grant to SERVE_I.
REQ-043 With simultaneous i_req and d_req and starve_cnt < STARVE_MAX, data SHALL win, since the MEM-stage instruction is older.
REQ-044 There SHALL be no timeout: the FSM SHALL wait indefinitely for mem_ack.

Reset
REQ-045 When rst=0, state SHALL be IDLE immediately (asynchronous).
REQ-046 When rst=0, starve_cnt, the latched registers, i_rdata, d_rdata, i_valid, d_valid, mem_req, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-047 Reset mid-transaction SHALL abandon the access with no valid pulse, and the first grant decision SHALL follow rst release.

Verification
REQ-048 Fetch: i_req=1, i_addr=0x10 at cycle 0, mem_ack=1 with mem_rdata=0x00500093 at cycle 3 -> mem_req=1 cycles 1-3, mem_addr=0x10, i_valid=1 at cycle 4 only, i_rdata=0x00500093, stall_if=1 cycles 0-3.
REQ-049 Contention: i_req=d_req=1 at cycle 0, d_we=0, immediate acks -> SERVE_D first, d_valid at cycle 2, then SERVE_I, i_valid at cycle 5.
REQ-050 Starvation: i_req and d_req held, acks immediate, STARVE_MAX=4 -> four data grants, the fifth grant goes to instruction, starve_cnt returns to 0.
REQ-051 Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_rdata previously 0x12345678 -> mem_we=1, mem_wdata=0xDEADBEEF, d_valid pulses, d_rdata stays 0x12345678.
REQ-052 Reset mid-access: rst=0 during SERVE_D before mem_ack -> mem_req=0 and all outputs 0 without waiting for a clock edge, no d_valid; after rst=1, a held d_req is re-granted.
REQ-053 Spurious ack: mem_ack=1 while IDLE with no requests -> no valid pulse, and state and outputs unchanged.
